operand_fwd_stage: RTL

- ID/EX pipeline stage for the 64-bit datapath.
- Registers decoded operands and tracks destination registers of in-flight instructions.
- Produces registered 2-bit selects for the two downstream 64-bit 4:1 operand muxes that feed the ALU:
  - 00 = regfile
  - 01 = EX/MEM forward
  - 10 = MEM/WB forward
  - 11 = immediate
- Detects load-use hazards and stalls ID while inserting a bubble into EX.

---
 rtl/operand_fwd_stage.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/operand_fwd_stage.sv
// ID/EX operand stage: registers decoded operands, resolves forwarding selects and load-use stalls.
// Optional OPFWD_STATS_EN adds saturating stall/forward event counters.
module operand_fwd_stage #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rn_data,
    input  logic [DATA_W-1:0] id_rm_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              freeze,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rn_data,
    output logic [DATA_W-1:0] ex_rm_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
`ifdef OPFWD_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt,
`endif
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b
);

    localparam logic [REG_W-1:0] ZeroIdx = REG_W'(ZERO_REG);

    typedef enum logic [1:0] {
        SelRegfile = 2'b00,
        SelExMem   = 2'b01,
        SelMemWb   = 2'b10,
        SelImm     = 2'b11
    } sel_e;

    // ID/EX pipeline register
    logic              ex_valid_q, ex_valid_d;
    logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q, ex_memread_d;
    logic [DATA_W-1:0] ex_rn_data_q, ex_rn_data_d;
    logic [DATA_W-1:0] ex_rm_data_q, ex_rm_data_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    sel_e              sel_a_q, sel_a_d;
    sel_e              sel_b_q, sel_b_d;

    // Shadow of the instruction now in EX/MEM
    logic              sh_valid_q, sh_valid_d;
    logic [REG_W-1:0]  sh_rd_q, sh_rd_d;
    logic              sh_regwrite_q, sh_regwrite_d;

    logic advance;
    logic hazard;
    logic bubble;
    sel_e sel_a_raw;
    sel_e sel_b_raw;

    function automatic sel_e fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             exm_valid,
        input logic             exm_regwrite,
        input logic [REG_W-1:0] exm_rd,
        input logic             mwb_valid,
        input logic             mwb_regwrite,
        input logic [REG_W-1:0] mwb_rd
    );
        sel_e sel;
        sel = SelRegfile;
        if (src != ZeroIdx) begin
            if (exm_valid && exm_regwrite && (exm_rd == src)) begin
                sel = SelExMem;
            end else if (mwb_valid && mwb_regwrite && (mwb_rd == src)) begin
                sel = SelMemWb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        hazard = ex_valid_q && ex_memread_q && ex_regwrite_q && (ex_rd_q != ZeroIdx) &&
                 id_valid &&
                 ((ex_rd_q == id_rn) || ((ex_rd_q == id_rm) && !id_alusrc));
        advance  = !freeze;
        // Flush and hazard both squash the ID instruction on its way into EX.
        bubble   = flush || hazard;
        id_ready = reset_n && !freeze && !hazard;
    end

    always_comb begin
        sel_a_raw = fwd_sel(id_rn, ex_valid_q, ex_regwrite_q, ex_rd_q,
                            sh_valid_q, sh_regwrite_q, sh_rd_q);
        if (id_alusrc) begin
            sel_b_raw = SelImm;
        end else begin
            sel_b_raw = fwd_sel(id_rm, ex_valid_q, ex_regwrite_q, ex_rd_q,
                                sh_valid_q, sh_regwrite_q, sh_rd_q);
        end
    end

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rd_d       = ex_rd_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        ex_rn_data_d  = ex_rn_data_q;
        ex_rm_data_d  = ex_rm_data_q;
        ex_imm_d      = ex_imm_q;
        sel_a_d       = sel_a_q;
        sel_b_d       = sel_b_q;
        sh_valid_d    = sh_valid_q;
        sh_rd_d       = sh_rd_q;
        sh_regwrite_d = sh_regwrite_q;
        if (advance) begin
            sh_valid_d    = ex_valid_q;
            sh_rd_d       = ex_rd_q;
            sh_regwrite_d = ex_regwrite_q;
            ex_rd_d       = id_rd;
            ex_rn_data_d  = id_rn_data;
            ex_rm_data_d  = id_rm_data;
            ex_imm_d      = id_imm;
            if (bubble) begin
                ex_valid_d    = 1'b0;
                ex_regwrite_d = 1'b0;
                ex_memread_d  = 1'b0;
                sel_a_d       = SelRegfile;
                sel_b_d       = SelRegfile;
            end else begin
                ex_valid_d    = id_valid;
                ex_regwrite_d = id_regwrite;
                ex_memread_d  = id_memread;
                sel_a_d       = sel_a_raw;
                sel_b_d       = sel_b_raw;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_rn_data_q  <= '0;
            ex_rm_data_q  <= '0;
            ex_imm_q      <= '0;
            sel_a_q       <= SelRegfile;
            sel_b_q       <= SelRegfile;
            sh_valid_q    <= 1'b0;
            sh_rd_q       <= '0;
            sh_regwrite_q <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rd_q       <= ex_rd_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_rn_data_q  <= ex_rn_data_d;
            ex_rm_data_q  <= ex_rm_data_d;
            ex_imm_q      <= ex_imm_d;
            sel_a_q       <= sel_a_d;
            sel_b_q       <= sel_b_d;
            sh_valid_q    <= sh_valid_d;
            sh_rd_q       <= sh_rd_d;
            sh_regwrite_q <= sh_regwrite_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rd       = ex_rd_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_rn_data  = ex_rn_data_q;
    assign ex_rm_data  = ex_rm_data_q;
    assign ex_imm      = ex_imm_q;
    assign sel_a       = sel_a_q;
    assign sel_b       = sel_b_q;

`ifdef OPFWD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic        stall_inc;
    logic        fwd_inc;

    always_comb begin
        // A flushed cycle is charged to the branch, not to the load-use stall.
        stall_inc = advance && hazard && !flush;
        fwd_inc   = advance && !bubble && id_valid &&
                    ((sel_a_raw == SelExMem) || (sel_a_raw == SelMemWb) ||
                     (sel_b_raw == SelExMem) || (sel_b_raw == SelMemWb));
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (fwd_inc && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
